mem_stage_wb: RTL and testbench
===============================

Name: mem_stage_wb

Overview:
- MEM stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and runs loads and stores on a data-memory bus with a req/ready handshake.
- Raises StallM while an access is outstanding, aborts an access on timeout, and registers the results for the WB stage.

Parameters:
- DATA_W, 32, data width of the memory bus and datapath.
- ADDR_W, 32, address width; the address is the low ADDR_W bits of ALUOutM.
- REG_W, 5, destination register index width.
- TIMEOUT, 16, maximum cycles to wait for dmem_ready; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active high.
- RegWriteM  in  1  register write enable from EX/MEM.
- MemtoRegM  in  1  load instruction.
- MemWriteM  in  1  store instruction.
- ALUOutM  in  DATA_W  effective address / ALU result.
- WriteDataM  in  DATA_W  store data.
- WriteRegM  in  REG_W  destination register.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  write data.
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready = 1.
- dmem_ready  in  1  access completes this cycle.
- StallM  out  1  to hazard unit; holds PC, IF/ID, ID/EX and EX/MEM.
- RegWriteW  out  1  to WB.
- MemtoRegW  out  1  to WB.
- ReadDataW  out  DATA_W  load data.
- ALUOutW  out  DATA_W  ALU result.
- WriteRegW  out  REG_W  destination register.
- BusErrW  out  1  one-cycle pulse: the access was misaligned or timed out.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). While rst = 1, all W outputs and BusErrW are 0, the FSM is IDLE, the counter is 0, and dmem_req and StallM are forced 0 (gated by ~rst).
- Combinational terms:
  - memop = MemtoRegM | MemWriteM.
  - misal = memop & (ALUOutM[1:0] != 0).
  - go = memop & ~misal.
- dmem_addr = ALUOutM[ADDR_W-1:0]; dmem_wdata = WriteDataM; dmem_we = MemWriteM. All three are combinational passthroughs.
- FSM states: IDLE and WAIT. Counter cnt, width clog2(TIMEOUT+1).
- IDLE:
  - dmem_req = go.
  - go & dmem_ready: zero-wait access; StallM = 0; W registers capture at the edge; stay IDLE.
  - go & ~dmem_ready: StallM = 1; next state WAIT; cnt <= 1.
  - Otherwise: StallM = 0; W registers capture at the edge.
- WAIT:
  - dmem_req = 1.
  - dmem_ready: StallM = 0; capture at the edge; next state IDLE.
  - ~dmem_ready and TIMEOUT != 0 and cnt == TIMEOUT: abort. dmem_req = 0 this cycle, StallM = 0, the bubble rule applies (RegWriteW <= 0), BusErrW <= 1, next state IDLE.
  - Otherwise: StallM = 1; cnt <= cnt + 1.
- Capture (non-stall, non-abort edge):
  - RegWriteW <= RegWriteM & ~misal.
  - MemtoRegW <= MemtoRegM & ~misal.
  - ReadDataW <= MemtoRegM ? dmem_rdata : 0.
  - ALUOutW <= ALUOutM; WriteRegW <= WriteRegM.
  - BusErrW <= misal.
- Bubble: on every edge where StallM = 1, RegWriteW <= 0, MemtoRegW <= 0 and BusErrW <= 0. The other W fields hold their values.
- Misaligned access: no request and no stall. The instruction retires with its register write suppressed and BusErrW pulsed for one cycle.
- Latency:
  - Zero-wait access: 1 cycle, M inputs to W outputs.
  - N-cycle memory: StallM is high for N-1 cycles.
- Handshake rule: while dmem_req = 1 and dmem_ready = 0, the M inputs are stable because upstream is stalled. The block does not latch its inputs.
- Reset mid-access abandons the access: dmem_req drops asynchronously with rst.
- dmem_ready while dmem_req = 0 is ignored.

Decomposition:
- Shared pipeline package: state enum {IDLE, WAIT}, the DATA_W/REG_W defaults, and the width function for the counter.
- One sub-module, mem_wb_reg: the MEM/WB register with capture, bubble and async-reset controls.
- The FSM, counter and bus logic stay in mem_stage_wb.

Test Plan:
- Store, zero-wait: MemWriteM = 1, ALUOutM = 0x100, WriteDataM = 0xCAFEF00D, dmem_ready = 1 the same cycle → dmem_req = 1, dmem_we = 1, dmem_addr = 0x100, StallM = 0; next cycle RegWriteW = 0, BusErrW = 0.
- Load, 3-cycle memory: MemtoRegM = 1, RegWriteM = 1, WriteRegM = 5, ready on the 3rd cycle with rdata = 0x12345678 → StallM high for 2 cycles with RegWriteW = 0 throughout; then RegWriteW = 1, ReadDataW = 0x12345678, WriteRegW = 5 for one cycle.
- Misaligned load: ALUOutM = 0x102 → dmem_req = 0, StallM = 0; next cycle RegWriteW = 0 and BusErrW = 1 for exactly one cycle.
- Timeout: TIMEOUT = 4, load with dmem_ready stuck at 0 → StallM high for 4 cycles, then low; RegWriteW = 0, BusErrW = 1 for one cycle; FSM returns to IDLE.
- Reset in WAIT: assert rst asynchronously between clock edges → dmem_req and StallM drop immediately; all W outputs read 0; after release, a zero-wait load completes normally.
- Back-to-back ALU ops (memop = 0) interleaved with zero-wait loads → StallM never asserts; W outputs track the M inputs with exactly one cycle of delay.

Source files
------------

// File: rtl/mem_stage_wb_pkg.sv
// Shared definitions for the MEM stage: FSM states, datapath width defaults
// and sizing of the access timeout counter.
package mem_stage_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Never narrower than one bit, so a disabled timeout still gives a legal counter.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_stage_wb_mem_wb_reg.sv
// MEM/WB pipeline register: loads a full result on capture, otherwise inserts
// a bubble (write enables cleared, data fields held, bus error from abort).
module mem_wb_reg
  import mem_stage_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              abort,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic              buserr_m,
  input  logic [DATA_W-1:0] readdata_m,
  input  logic [DATA_W-1:0] aluout_m,
  input  logic [REG_W-1:0]  writereg_m,
  output logic              regwrite_w,
  output logic              memtoreg_w,
  output logic              buserr_w,
  output logic [DATA_W-1:0] readdata_w,
  output logic [DATA_W-1:0] aluout_w,
  output logic [REG_W-1:0]  writereg_w
);

  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              buserr_q,   buserr_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic [DATA_W-1:0] aluout_q,   aluout_d;
  logic [REG_W-1:0]  writereg_q, writereg_d;

  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    buserr_d   = buserr_q;
    readdata_d = readdata_q;
    aluout_d   = aluout_q;
    writereg_d = writereg_q;
    if (capture) begin
      regwrite_d = regwrite_m;
      memtoreg_d = memtoreg_m;
      buserr_d   = buserr_m;
      readdata_d = readdata_m;
      aluout_d   = aluout_m;
      writereg_d = writereg_m;
    end else begin
      // Stall and abort edges both retire nothing; only an abort flags an error.
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      buserr_d   = abort;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      buserr_q   <= 1'b0;
      readdata_q <= '0;
      aluout_q   <= '0;
      writereg_q <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      buserr_q   <= buserr_d;
      readdata_q <= readdata_d;
      aluout_q   <= aluout_d;
      writereg_q <= writereg_d;
    end
  end

  assign regwrite_w = regwrite_q;
  assign memtoreg_w = memtoreg_q;
  assign buserr_w   = buserr_q;
  assign readdata_w = readdata_q;
  assign aluout_w   = aluout_q;
  assign writereg_w = writereg_q;

endmodule

// File: rtl/mem_stage_wb.sv
// MEM stage: drives the data-memory handshake, stalls upstream while an access
// is outstanding, aborts on timeout and feeds the MEM/WB register.
//   state | meaning
//   IDLE  | no access outstanding; zero-wait and non-memory ops retire here
//   WAIT  | request held until dmem_ready or the timeout count expires
module mem_stage_wb
  import mem_stage_wb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 32,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [REG_W-1:0]  WriteRegM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              StallM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [REG_W-1:0]  WriteRegW,
  output logic              BusErrW
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic memop, misal, go;
  logic req_c, stall_c, abort_c, capture;

  assign memop = MemtoRegM | MemWriteM;
  assign misal = memop & (ALUOutM[1:0] != 2'b00);
  assign go    = memop & ~misal;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_c = go;
        if (go && !dmem_ready) begin
          stall_c = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (dmem_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
          req_c   = 1'b0;
          abort_c = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          // With the timeout disabled the count is meaningless; keep it parked.
          if (TIMEOUT != 0) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must drop the request and stall immediately, not at the next edge.
  assign dmem_req   = req_c & ~rst;
  assign StallM     = stall_c & ~rst;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUOutM[ADDR_W-1:0];
  assign dmem_wdata = WriteDataM;

  assign capture = ~stall_c & ~abort_c;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .abort      (abort_c),
    .regwrite_m (RegWriteM & ~misal),
    .memtoreg_m (MemtoRegM & ~misal),
    .buserr_m   (misal),
    .readdata_m (MemtoRegM ? dmem_rdata : '0),
    .aluout_m   (ALUOutM),
    .writereg_m (WriteRegM),
    .regwrite_w (RegWriteW),
    .memtoreg_w (MemtoRegW),
    .buserr_w   (BusErrW),
    .readdata_w (ReadDataW),
    .aluout_w   (ALUOutW),
    .writereg_w (WriteRegW)
  );

endmodule

// File: tb/tb_mem_stage_wb.sv
// Scoreboard bench for mem_stage_wb: an instruction-level reference model
// predicts stall length, bus signals and the retired W values per instruction.
module tb_mem_stage_wb;

  localparam int TMO = 4;

  logic        clk, rst;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready, StallM;
  logic        RegWriteW, MemtoRegW, BusErrW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  mem_stage_wb #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .BusErrW(BusErrW)
  );

  typedef struct {
    int          stalls;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic        rw, m2r, berr;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] held_rd = '0, held_alu = '0;
  logic [4:0]  held_wr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one instruction: predict its outcome, then drive it for as many
  // cycles as the memory model says it occupies the stage.
  // n = cycle (1-based) on which dmem_ready rises; beyond TMO+1 it never arrives.
  task automatic issue(input logic rw, input logic m2r, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input int n, input logic [31:0] rdf);
    exp_t e;
    logic memop, misal, go, abort;
    int   cyc;
    memop = m2r | mw;
    misal = memop && (alu[1:0] != 2'b00);
    go    = memop && !misal;
    abort = go && (n > TMO + 1);
    cyc   = !go ? 1 : (abort ? TMO + 1 : n);
    e.stalls = cyc - 1;
    e.req    = go && !abort;
    e.we     = mw;
    e.addr   = alu;
    e.wdata  = wd;
    if (abort) begin
      e.rw = 1'b0; e.m2r = 1'b0; e.berr = 1'b1;
      e.rd = held_rd; e.alu = held_alu; e.wr = held_wr;
    end else begin
      e.rw = rw && !misal; e.m2r = m2r && !misal; e.berr = misal;
      e.rd = m2r ? rdf : 32'h0; e.alu = alu; e.wr = wr;
      held_rd = e.rd; held_alu = e.alu; held_wr = e.wr;
    end
    sb.push_back(e);
    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    for (int k = 1; k <= cyc; k++) begin
      dmem_ready = go ? (k == n) : 1'($urandom_range(0, 1));
      dmem_rdata = (k == cyc) ? rdf : $urandom;
      @(posedge clk); #2;
    end
  endtask

  // Monitor: every stalled edge must be a bubble; every non-stalled edge retires
  // the oldest scoreboard entry.
  initial begin
    int          stall_cnt;
    logic        st, rq, we;
    logic [31:0] addr, wdata;
    exp_t        e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst) begin
        stall_cnt = 0;
        continue;
      end
      st = StallM; rq = dmem_req; we = dmem_we; addr = dmem_addr; wdata = dmem_wdata;
      @(posedge clk); #1;
      if (st) begin
        stall_cnt++;
        chk("req_during_stall", 32'(rq), 32'd1);
        chk("bubble_regwrite", 32'(RegWriteW), 32'd0);
        chk("bubble_memtoreg", 32'(MemtoRegW), 32'd0);
        chk("bubble_buserr", 32'(BusErrW), 32'd0);
      end else if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL retire_unexpected: got retirement expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        chk("dmem_req", 32'(rq), 32'(e.req));
        chk("dmem_we", 32'(we), 32'(e.we));
        chk("dmem_addr", addr, e.addr);
        chk("dmem_wdata", wdata, e.wdata);
        chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
        chk("MemtoRegW", 32'(MemtoRegW), 32'(e.m2r));
        chk("BusErrW", 32'(BusErrW), 32'(e.berr));
        chk("ReadDataW", ReadDataW, e.rd);
        chk("ALUOutW", ALUOutW, e.alu);
        chk("WriteRegW", 32'(WriteRegW), 32'(e.wr));
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int r, n;
    logic [31:0] a;
    rst = 1'b1;
    RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
    ALUOutM = '0; WriteDataM = '0; WriteRegM = '0;
    dmem_rdata = '0; dmem_ready = 0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_StallM", 32'(StallM), 32'd0);
    chk("reset_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset_BusErrW", 32'(BusErrW), 32'd0);
    chk("reset_ALUOutW", ALUOutW, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed cases
    issue(1'b0, 1'b0, 1'b1, 32'h100, 32'hCAFEF00D, 5'd0, 1, 32'h0);    // store, zero-wait
    issue(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd5, 3, 32'h12345678);    // load, 3-cycle
    issue(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd7, 1, 32'hDEADBEEF);    // misaligned load
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, 100, 32'h0);          // timeout
    issue(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 5'd10, TMO + 1, 32'hA5A5A5A5); // ready on last allowed cycle
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i), 32'h0, 5'(i + 1), 1, $urandom);
      issue(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 5'(i + 11), 1, $urandom);
    end

    // Reset while waiting on memory
    mon_en = 1'b0;
    RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0; ALUOutM = 32'h400; WriteRegM = 5'd3;
    dmem_ready = 0;
    @(posedge clk); #2;
    @(posedge clk); #3;
    chk("wait_StallM_before_rst", 32'(StallM), 32'd1);
    chk("wait_req_before_rst", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(dmem_req), 32'd0);
    chk("rst_async_StallM", 32'(StallM), 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_MemtoRegW", 32'(MemtoRegW), 32'd0);
    chk("rst_ReadDataW", ReadDataW, 32'd0);
    chk("rst_ALUOutW", ALUOutW, 32'd0);
    chk("rst_WriteRegW", 32'(WriteRegW), 32'd0);
    chk("rst_BusErrW", 32'(BusErrW), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    held_rd = '0; held_alu = '0; held_wr = '0;
    mon_en = 1'b1;
    issue(1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 5'd4, 1, 32'h0BADF00D);

    // Randomised mix
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(1, TMO + 3);
      a = {$urandom, 2'b00} ;
      if (r <= 3)
        issue(1'($urandom), 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1, $urandom);
      else if (r <= 6)
        issue(1'($urandom), 1'b1, 1'b0, a, $urandom, 5'($urandom), n, $urandom);
      else if (r <= 8)
        issue(1'($urandom), 1'b0, 1'b1, a, $urandom, 5'($urandom), n, $urandom);
      else
        issue(1'($urandom), 1'($urandom), 1'b1, a | 32'($urandom_range(1, 3)),
              $urandom, 5'($urandom), n, $urandom);
    end

    mon_en = 1'b0;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
